// File: rtl/obuf_drain.sv
`default_nettype none
// ============================================================================
// Module   : obuf_drain
// Purpose  : Pops accumulated rows from the output buffer, requantizes each
//            column's wide signed accumulator to signed 8 bits (round, shift,
//            saturate) and presents one packed row per valid/ready handshake.
// Options  : define OBUF_DRAIN_RELU_EN to clamp negative accumulators to zero
//            before rounding (output range becomes [0,127]).
// Revision : 1.0 - initial release
// ============================================================================
module obuf_drain #(
    parameter int ARRAY_SIZE     = 8,
    parameter int LOG_ARRAY_SIZE = 3,
    parameter int COL_WIDTH      = 10 + LOG_ARRAY_SIZE
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [LOG_ARRAY_SIZE:0]             num_rows,
    input  logic [5:0]                          shift,
    output logic                                read_o,
    input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0]   obuf_out,
    output logic [ARRAY_SIZE*8-1:0]             out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                out_last,
    output logic                                busy,
    output logic                                done
);

    localparam int c_ACC_W = COL_WIDTH * 4;

    // Shift amounts at or above the accumulator width collapse to the sign.
    localparam logic [5:0] c_SHIFT_SAT = 6'(c_ACC_W);

    localparam logic [LOG_ARRAY_SIZE:0] c_MAX_ROWS = (LOG_ARRAY_SIZE+1)'(ARRAY_SIZE);
    localparam logic [LOG_ARRAY_SIZE:0] c_ROW_ONE  = (LOG_ARRAY_SIZE+1)'(1);

    localparam logic signed [c_ACC_W:0] c_ONE  = (c_ACC_W+1)'(1);
    localparam logic signed [c_ACC_W:0] c_QMAX = (c_ACC_W+1)'(127);
`ifdef OBUF_DRAIN_RELU_EN
    localparam logic signed [c_ACC_W:0] c_QMIN = (c_ACC_W+1)'(0);
`else
    localparam logic signed [c_ACC_W:0] c_QMIN = (c_ACC_W+1)'(-128);
`endif

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_READ    = 3'd1;
    localparam logic [2:0] c_ST_CAPTURE = 3'd2;
    localparam logic [2:0] c_ST_HOLD    = 3'd3;
    localparam logic [2:0] c_ST_FIN     = 3'd4;

    logic [2:0]                r_state;
    logic [LOG_ARRAY_SIZE:0]   r_rows;
    logic [LOG_ARRAY_SIZE:0]   r_row_cnt;
    logic [5:0]                r_shift;
    logic [ARRAY_SIZE*8-1:0]   w_quant;

    // Per-column requantization of the current obuf row using the latched shift.
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col
        logic signed [c_ACC_W-1:0] w_acc;
        logic signed [c_ACC_W:0]   w_ext;
        logic signed [c_ACC_W:0]   w_rnd;
        logic signed [c_ACC_W:0]   w_r;
        logic [7:0]                w_q;

        assign w_acc = obuf_out[c*c_ACC_W +: c_ACC_W];
`ifdef OBUF_DRAIN_RELU_EN
        assign w_ext = w_acc[c_ACC_W-1] ? '0 : {1'b0, w_acc};
`else
        assign w_ext = {w_acc[c_ACC_W-1], w_acc};
`endif

        // Round half-up, arithmetic shift, then saturate to the 8-bit range.
        always_comb begin
            w_rnd = w_ext + (c_ONE <<< (r_shift - 6'd1));
            w_r   = w_ext;
            if (r_shift >= c_SHIFT_SAT) begin
                w_r = {(c_ACC_W+1){w_ext[c_ACC_W]}};
            end else if (r_shift != 6'd0) begin
                w_r = w_rnd >>> r_shift;
            end
            if (w_r > c_QMAX) begin
                w_q = c_QMAX[7:0];
            end else if (w_r < c_QMIN) begin
                w_q = c_QMIN[7:0];
            end else begin
                w_q = w_r[7:0];
            end
        end

        assign w_quant[c*8 +: 8] = w_q;
    end

    // Drain sequencer: one pop, one capture, then hold until the consumer takes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_ST_IDLE;
            r_rows    <= '0;
            r_row_cnt <= '0;
            r_shift   <= '0;
            read_o    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_row_cnt <= '0;
                        busy      <= 1'b1;
                        if (num_rows == '0) begin
                            done    <= 1'b1;
                            r_state <= c_ST_FIN;
                        end else begin
                            r_rows  <= (num_rows > c_MAX_ROWS) ? c_MAX_ROWS : num_rows;
                            r_shift <= shift;
                            read_o  <= 1'b1;
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_READ: begin
                    read_o  <= 1'b0;
                    r_state <= c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    out_data  <= w_quant;
                    out_valid <= 1'b1;
                    out_last  <= (r_row_cnt == r_rows - c_ROW_ONE);
                    r_state   <= c_ST_HOLD;
                end
                c_ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        r_row_cnt <= r_row_cnt + c_ROW_ONE;
                        // out_last already marks the final row of this drain.
                        if (out_last) begin
                            done    <= 1'b1;
                            r_state <= c_ST_FIN;
                        end else begin
                            read_o  <= 1'b1;
                            r_state <= c_ST_READ;
                        end
                    end
                end
                c_ST_FIN: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    read_o    <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/obuf_drain.md
Name: obuf_drain

Overview:
- Downstream consumer of the accelerator output buffer.
- Pops accumulated rows from obuf with read_o and requantizes each column's wide signed accumulator to signed 8-bit (round, shift, saturate).
- Presents one packed row of ARRAY_SIZE bytes per valid/ready handshake. Output format matches the ibuf_in row format, so results can feed the next layer.

Parameters:
- ARRAY_SIZE, 8, number of columns per obuf row.
- LOG_ARRAY_SIZE, 3, log2(ARRAY_SIZE).
- COL_WIDTH, 10+LOG_ARRAY_SIZE, base column width; each column accumulator is COL_WIDTH*4 bits, signed two's complement.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins draining num_rows rows; sampled only in IDLE.
- num_rows  in  LOG_ARRAY_SIZE+1  rows to drain; sampled with start.
- shift  in  6  right-shift amount for requantization; sampled with start.
- read_o  out  1  obuf pop strobe; obuf_out valid the cycle after.
- obuf_out  in  ARRAY_SIZE*COL_WIDTH*4  one obuf row; column c at bits [c*COL_WIDTH*4 +: COL_WIDTH*4].
- out_data  out  ARRAY_SIZE*8  requantized row; column c at bits [c*8 +: 8].
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_last  out  1  high with out_valid on the final row.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final row is accepted.

Behaviour:
- Reset (rst==0 at a clock edge): state IDLE; read_o, out_valid, out_last, busy, done = 0; out_data = 0; row counter = 0. Applies mid-operation; any row in flight is discarded.
- All outputs are registered.
- States: IDLE, READ, CAPTURE, HOLD, FIN.
- IDLE:
  - start=1, num_rows>0: latch num_rows (values >ARRAY_SIZE clamp to ARRAY_SIZE) and shift; go to READ.
  - start=1, num_rows=0: go to FIN; read_o never asserted.
- READ: read_o=1 for exactly this cycle; go to CAPTURE.
- CAPTURE: register requantized obuf_out into out_data; set out_last if this is the final row; go to HOLD.
- HOLD: out_valid=1.
  - out_data and out_last stay stable while out_ready=0.
  - On handshake: increment row counter; if rows remain go to READ, else go to FIN.
- FIN: done=1 for one cycle; return to IDLE.
- Latency: first out_valid is 3 cycles after the start edge. Minimum 3 cycles per row with out_ready held high.
- start outside IDLE is ignored. num_rows/shift changes after sampling are ignored.
- Requantization per column, acc signed COL_WIDTH*4 bits, computed at COL_WIDTH*4+1 bits:
  - shift==0: r = acc.
  - shift>0: r = (acc + 2^(shift-1)) >>> shift, arithmetic shift.
  - shift >= COL_WIDTH*4: r = 0 for non-negative acc, -1 for negative acc.
  - Saturate r to [-128,127].
- read_o is never asserted while out_valid=1, so at most one row is held and obuf is never over-popped.

Optional Feature:
- Macro OBUF_DRAIN_RELU_EN.
- Defined: negative acc is forced to 0 before rounding; saturation range becomes [0,127].
- Undefined: signed saturation to [-128,127] as above; no ReLU logic is synthesized.

Test Plan:
- Basic drain: start, num_rows=2, shift=0. Row0 cols = 100,-5,127,-128,0,1,-1,50. Expect out_data bytes 64,FB,7F,80,00,01,FF,32; first out_valid 3 cycles after start; out_last only on row1; done one cycle after the row1 handshake.
- Saturation / rounding:
  - shift=0, cols 300 / -300 -> 7F / 80.
  - shift=2, cols 10 / -10 / 6 -> 03 / FE / 02.
  - shift=60, col -7 -> FF.
- Backpressure: out_ready=0 for 5 cycles during HOLD. out_data stable, read_o stays 0, exactly num_rows read_o pulses in total; with out_ready=1 throughout, read_o pulses are 3 cycles apart.
- Boundaries:
  - num_rows=0 -> done one cycle after start, no read_o, no out_valid.
  - num_rows=12 -> exactly 8 rows.
  - start pulsed while busy -> ignored.
- Reset mid-operation: rst=0 during HOLD of row 1 of 4 -> next cycle all outputs 0, IDLE. A following start with num_rows=1 drains normally.
- OBUF_DRAIN_RELU_EN defined: cols -300,-1,200 at shift=0 -> 00,00,7F.
